fp32_recip_nr_vec: RTL

Multi-lane FP32 reciprocal (1/x) unit for softmax normalisation and layer-norm scaling in the EPU attention path. Each lane takes a LUT seed of 1/mantissa, then optionally refines it with up to NR_ITERS Newton-Raphson steps (y = y*(2 - m*y)) in fixed point. The block uses valid/ready handshakes on both sides and is a multi-cycle FSM that holds one vector transaction at a time. It replaces the single-lane, seed-only, 1-cycle reciprocal: it adds lanes, accuracy control, signed operands, underflow flush and backpressure.

---
 rtl/fp32_recip_nr_vec.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp32_recip_nr_vec.sv
`default_nettype none
// ============================================================================
// Module   : fp32_recip_nr_vec
// Purpose  : Multi-lane FP32 reciprocal (1/x). Each lane takes a midpoint LUT
//            seed of 1/mantissa and, when requested, refines it with NR_ITERS
//            Newton-Raphson steps y = y*(2 - m*y) in unsigned Q2.(Y_W-2).
//            One vector is in flight at a time, with valid/ready on both sides.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            in_valid/in_ready - input handshake, in_data = LANES x FP32
//            in_refine         - 1: run NR steps, 0: seed only (sampled at accept)
//            out_valid/out_ready - output handshake, out_data = LANES x FP32
//            out_special       - per lane: zero/denorm/inf/NaN/underflow path
//            busy              - FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module fp32_recip_nr_vec #(
  parameter int LANES    = 4,
  parameter int M_BITS   = 6,
  parameter int NR_ITERS = 2,
  parameter int Y_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_data,
  input  logic                  in_refine,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*32-1:0]   out_data,
  output logic [LANES-1:0]      out_special,
  output logic                  busy
);

  // Fractional bits of the reciprocal register (needs Y_W >= 25 for packing).
  localparam int              c_FB    = Y_W - 2;
  localparam int              c_LUT_N = 1 << M_BITS;
  localparam int              c_CNT_W = $clog2(NR_ITERS + 2);
  localparam logic [31:0]     c_ITERS = NR_ITERS;
  // 2.0 in Q2.(Y_W-2)
  localparam logic [Y_W-1:0]  c_TWO   = {2'b10, {c_FB{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEED = 3'd1,
    S_MUL  = 3'd2,
    S_UPD  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t                state_q;
  logic                  started_q;
  logic [LANES*32-1:0]   x_q;
  logic                  refine_q;
  logic [c_CNT_W-1:0]    cnt_q;
  logic [Y_W-1:0]        y_q [LANES];
  logic [Y_W-1:0]        t_q [LANES];
  logic [LANES*32-1:0]   out_data_q;
  logic [LANES-1:0]      out_special_q;
  logic                  out_valid_q;

  logic                  accept_d;

  // Per-lane next values and packed candidates for the two ways of entering OUT
  logic [Y_W-1:0]        seed_d [LANES];
  logic [Y_W-1:0]        t_d    [LANES];
  logic [Y_W-1:0]        upd_d  [LANES];
  logic [LANES*32-1:0]   seed_data_d;
  logic [LANES-1:0]      seed_spec_d;
  logic [LANES*32-1:0]   upd_data_d;
  logic [LANES-1:0]      upd_spec_d;

  // ---------------------------------------------------------------------------
  // Seed table: floor(1/m_mid) in Q2.(Y_W-2), m_mid = 1 + (2*idx+1)/2^(M_BITS+1)
  // ---------------------------------------------------------------------------
  logic [Y_W-1:0] lut [c_LUT_N];

  for (genvar gi = 0; gi < c_LUT_N; gi++) begin : g_lut
    localparam logic [63:0] c_NUM = 64'd1 << (c_FB + M_BITS + 1);
    localparam logic [63:0] c_DEN = (64'd1 << (M_BITS + 1)) + 64'(2 * gi + 1);
    assign lut[gi] = Y_W'(c_NUM / c_DEN);
  end

  // ---------------------------------------------------------------------------
  // Pack one lane: returns {special, fp32}. Specials override the datapath.
  // ---------------------------------------------------------------------------
  function automatic logic [32:0] pack_lane(input logic [31:0] x,
                                            input logic [Y_W-1:0] y);
    logic              s;
    logic [7:0]        e;
    logic [22:0]       f;
    logic              ge1;
    logic [Y_W-1:0]    yn;
    logic signed [9:0] ex;
    logic [32:0]       r;
    s   = x[31];
    e   = x[30:23];
    f   = x[22:0];
    ge1 = (y >> c_FB) != '0;
    // y < 1.0 is normalised by one left shift, costing one exponent step
    yn  = ge1 ? y : (y << 1);
    ex  = ge1 ? (10'sd254 - $signed({2'b00, e}))
              : (10'sd253 - $signed({2'b00, e}));
    if (e == 8'd0) begin
      r = {1'b1, s, 8'hff, 23'd0};
    end else if (e == 8'hff) begin
      r = (f == 23'd0) ? {1'b1, s, 31'd0} : {1'b1, 32'h7fc0_0000};
    end else if (ex <= 10'sd0) begin
      // No denormal outputs: flush to signed zero
      r = {1'b1, s, 31'd0};
    end else begin
      r = {1'b0, s, ex[7:0], 23'(yn >> (c_FB - 23))};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Lane datapath
  // ---------------------------------------------------------------------------
  for (genvar gl = 0; gl < LANES; gl++) begin : g_lane
    logic [23:0]        m;
    logic [Y_W+23:0]    mprod;
    logic [Y_W-1:0]     two_m_t;
    logic [2*Y_W-1:0]   uprod;

    assign m       = {1'b1, x_q[32*gl +: 23]};
    // Q1.23 * Q2.(Y_W-2) -> drop 23 fraction bits; m*y stays below 2
    assign mprod   = (Y_W+24)'(m) * (Y_W+24)'(y_q[gl]);
    assign two_m_t = c_TWO - t_q[gl];
    assign uprod   = (2*Y_W)'(y_q[gl]) * (2*Y_W)'(two_m_t);

    assign seed_d[gl] = lut[x_q[32*gl+22 -: M_BITS]];
    assign t_d[gl]    = Y_W'(mprod >> 23);
    assign upd_d[gl]  = Y_W'(uprod >> c_FB);

    assign {seed_spec_d[gl], seed_data_d[32*gl +: 32]} =
             pack_lane(x_q[32*gl +: 32], seed_d[gl]);
    assign {upd_spec_d[gl], upd_data_d[32*gl +: 32]} =
             pack_lane(x_q[32*gl +: 32], upd_d[gl]);
  end

  // ---------------------------------------------------------------------------
  // Handshake and control
  // ---------------------------------------------------------------------------
  // started_q keeps in_ready low until the first edge after reset release
  assign in_ready    = started_q &
                       ((state_q == S_IDLE) | ((state_q == S_OUT) & out_ready));
  assign accept_d    = in_valid & in_ready;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_special = out_special_q;
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      started_q     <= 1'b0;
      x_q           <= '0;
      refine_q      <= 1'b0;
      cnt_q         <= '0;
      out_data_q    <= '0;
      out_special_q <= '0;
      out_valid_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        y_q[i] <= '0;
        t_q[i] <= '0;
      end
    end else begin
      started_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            x_q      <= in_data;
            refine_q <= in_refine;
            cnt_q    <= '0;
            state_q  <= S_SEED;
          end
        end
        S_SEED: begin
          for (int i = 0; i < LANES; i++) y_q[i] <= seed_d[i];
          if (refine_q && (c_ITERS != 32'd0)) begin
            state_q <= S_MUL;
          end else begin
            out_data_q    <= seed_data_d;
            out_special_q <= seed_spec_d;
            out_valid_q   <= 1'b1;
            state_q       <= S_OUT;
          end
        end
        S_MUL: begin
          for (int i = 0; i < LANES; i++) t_q[i] <= t_d[i];
          state_q <= S_UPD;
        end
        S_UPD: begin
          for (int i = 0; i < LANES; i++) y_q[i] <= upd_d[i];
          cnt_q <= cnt_q + 1'b1;
          if ((32'(cnt_q) + 32'd1) < c_ITERS) begin
            state_q <= S_MUL;
          end else begin
            // Pack straight from the final update so OUT is entered this edge
            out_data_q    <= upd_data_d;
            out_special_q <= upd_spec_d;
            out_valid_q   <= 1'b1;
            state_q       <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (accept_d) begin
              x_q      <= in_data;
              refine_q <= in_refine;
              cnt_q    <= '0;
              state_q  <= S_SEED;
            end else begin
              state_q  <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
